// File: rtl/cook_timer.sv
// cook_timer: microwave-style BCD countdown timer with keypad entry, pause and a timed done alarm.
module cook_timer #(
   parameter int DONE_SECS = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic [3:0] in,
   input  logic       pushButton,
   input  logic       onOff,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       heating,
   output logic       done,
   output logic [1:0] state
);
   localparam int CW = $clog2(DONE_SECS + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
   state_t state_q, state_d;
   logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
   logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic pb_q, pb_d, heating_q, heating_d, done_q, done_d;
   logic press, is_zero, dec_zero;
   assign press = pushButton & ~pb_q;
   assign is_zero = {mt_q, mo_q, st_q, so_q} == 16'h0000;
   assign cnt_inc = cnt_q + 1'b1;
   // One-second BCD borrow chain; only used while the time is nonzero.
   always_comb begin
      dec_so = (so_q != 4'd0) ? so_q - 4'd1 : 4'd9;
      dec_st = (so_q != 4'd0) ? st_q : (st_q != 4'd0) ? st_q - 4'd1 : 4'd5;
      dec_mo = (so_q != 4'd0 || st_q != 4'd0) ? mo_q : (mo_q != 4'd0) ? mo_q - 4'd1 : 4'd9;
      dec_mt = (so_q != 4'd0 || st_q != 4'd0 || mo_q != 4'd0) ? mt_q : mt_q - 4'd1;
      dec_zero = {dec_mt, dec_mo, dec_st, dec_so} == 16'h0000;
   end
   always_comb begin
      state_d = state_q;
      mt_d = mt_q;
      mo_d = mo_q;
      st_d = st_q;
      so_d = so_q;
      cnt_d = cnt_q;
      pb_d = pushButton;
      case (state_q)
         IDLE: begin
            if (press && in <= 4'd9) begin
               mt_d = mo_q;
               mo_d = st_q;
               st_d = so_q;
               so_d = in;
            end else if (press && in == 4'hA && !is_zero) begin
               state_d = RUN;
            end else if (press && in == 4'hC) begin
               {mt_d, mo_d, st_d, so_d} = 16'h0000;
            end
         end
         RUN: begin
            if (press && in == 4'hC) begin
               state_d = IDLE;
               {mt_d, mo_d, st_d, so_d} = 16'h0000;
            end else if (onOff) begin
               state_d = PAUSE;
            end else if (tick) begin
               {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
               state_d = dec_zero ? DONE : RUN;
               cnt_d = '0;
            end
         end
         PAUSE: begin
            if (press && in == 4'hC) begin
               state_d = IDLE;
               {mt_d, mo_d, st_d, so_d} = 16'h0000;
            end else if (press && in == 4'hA && !onOff) begin
               state_d = RUN;
            end
         end
         default: begin
            if (press) begin
               state_d = IDLE;
            end else if (tick) begin
               cnt_d = cnt_inc;
               state_d = (cnt_inc == CW'(DONE_SECS)) ? IDLE : DONE;
            end
         end
      endcase
      heating_d = state_d == RUN;
      done_d = state_d == DONE;
   end
   always_ff @(posedge clk) begin
      pb_q <= pb_d;
      if (reset) begin
         state_q <= IDLE;
         {mt_q, mo_q, st_q, so_q} <= 16'h0000;
         cnt_q <= '0;
         heating_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         {mt_q, mo_q, st_q, so_q} <= {mt_d, mo_d, st_d, so_d};
         cnt_q <= cnt_d;
         heating_q <= heating_d;
         done_q <= done_d;
      end
   end
   assign min_tens = mt_q;
   assign min_ones = mo_q;
   assign sec_tens = st_q;
   assign sec_ones = so_q;
   assign heating = heating_q;
   assign done = done_q;
   assign state = state_q;
endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed scoreboard bench for cook_timer (state, digits, heating, done).
module tb_cook_timer;
   logic clk = 1'b0;
   logic reset, tick, pushButton, onOff;
   logic [3:0] in, min_tens, min_ones, sec_tens, sec_ones;
   logic heating, done;
   logic [1:0] state;
   int n_assert = 0;
   int n_fail = 0;
   logic [19:0] sb[$];
   always #5 clk = ~clk;
   cook_timer #(.DONE_SECS(5)) dut (
      .clk(clk), .reset(reset), .tick(tick), .in(in), .pushButton(pushButton), .onOff(onOff),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .heating(heating), .done(done), .state(state)
   );
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic press(input logic [3:0] c);
      in = c;
      pushButton = 1'b1;
      step();
      pushButton = 1'b0;
      step();
   endtask
   task automatic tk();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask
   task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input int n);
      if (n > 2) press(a);
      if (n > 1) press(b);
      press(c);
   endtask
   // Expected word: {state, mm:ss digits, heating, done}.
   task automatic expect_out(input string tag, input logic [1:0] s, input logic [15:0] t);
      sb.push_back({s, t, s == 2'd1, s == 2'd3});
   endtask
   task automatic check(input string tag);
      logic [19:0] exp_v, obs;
      exp_v = sb.pop_front();
      obs = {state, min_tens, min_ones, sec_tens, sec_ones, heating, done};
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask
   task automatic ec(input string tag, input logic [1:0] s, input logic [15:0] t);
      expect_out(tag, s, t);
      check(tag);
   endtask
   initial begin
      reset = 1'b1; tick = 1'b0; onOff = 1'b0; in = 4'd7; pushButton = 1'b1;
      step(); step();
      ec("reset_state", 2'd0, 16'h0000);
      reset = 1'b0;
      step();
      ec("pb_held_through_reset", 2'd0, 16'h0000);
      pushButton = 1'b0;
      step();
      enter(4'd1, 4'd3, 4'd0, 3);
      ec("entry_0130", 2'd0, 16'h0130);
      press(4'hA);
      ec("start_run", 2'd1, 16'h0130);
      press(4'd7);
      ec("run_other_code_ignored", 2'd1, 16'h0130);
      press(4'hC);
      ec("run_clear", 2'd0, 16'h0000);
      enter(4'd1, 4'd0, 4'd0, 3); press(4'hA); tk();
      ec("borrow_0100", 2'd1, 16'h0059);
      press(4'hC);
      press(4'd1); enter(4'd0, 4'd0, 4'd0, 3); press(4'hA); tk();
      ec("borrow_1000", 2'd1, 16'h0959);
      press(4'hC);
      enter(4'd0, 4'd9, 4'd0, 2); press(4'hA); tk();
      ec("borrow_0090", 2'd1, 16'h0089);
      press(4'hC);
      enter(4'd0, 4'd0, 4'd2, 1); press(4'hA); tk();
      ec("count_0001", 2'd1, 16'h0001);
      tk();
      ec("reach_done", 2'd3, 16'h0000);
      for (int i = 0; i < 4; i++) tk();
      ec("done_held", 2'd3, 16'h0000);
      tk();
      ec("done_expired", 2'd0, 16'h0000);
      enter(4'd0, 4'd0, 4'd1, 1); press(4'hA); tk();
      ec("done_again", 2'd3, 16'h0000);
      press(4'd5);
      ec("done_press_idle", 2'd0, 16'h0000);
      enter(4'd0, 4'd3, 4'd0, 2); press(4'hA);
      onOff = 1'b1;
      tk();
      ec("pause_enter", 2'd2, 16'h0030);
      tk(); tk();
      ec("pause_frozen", 2'd2, 16'h0030);
      press(4'hA);
      ec("pause_A_door_open", 2'd2, 16'h0030);
      onOff = 1'b0;
      press(4'hA);
      ec("pause_resume", 2'd1, 16'h0030);
      tk();
      ec("resume_count", 2'd1, 16'h0029);
      in = 4'hC; pushButton = 1'b1; tick = 1'b1;
      step();
      pushButton = 1'b0; tick = 1'b0;
      step();
      ec("clear_beats_tick", 2'd0, 16'h0000);
      press(4'hA);
      ec("start_at_zero", 2'd0, 16'h0000);
      enter(4'd5, 4'd1, 4'd7, 3); press(4'hA); tk();
      ec("run_0516", 2'd1, 16'h0516);
      reset = 1'b1;
      step();
      reset = 1'b0;
      ec("reset_mid_run", 2'd0, 16'h0000);
      enter(4'd1, 4'd2, 4'd3, 3); enter(4'd0, 4'd4, 4'd5, 2);
      ec("shift_discard", 2'd0, 16'h2345);
      press(4'hA); onOff = 1'b1; step(); onOff = 1'b0;
      press(4'hC);
      ec("pause_clear", 2'd0, 16'h0000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 Parameter: DONE_SECS, default 5, number of 1 Hz ticks the done alarm is held before the block returns to IDLE.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-clk-wide 1 Hz enable from the seconds divider.
REQ-005 in  input  4  keypad/switch code: 0-9 = digit, 4'hA = start/resume, 4'hC = clear, others = no-op.
REQ-006 pushButton  input  1  active-high level, already synchronized; each rising edge commits the code on `in`.
REQ-007 onOff  input  1  0 = oven enabled/door closed; 1 = oven disabled/door open.
REQ-008 min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD remaining/entered time, feeding the sevenSeg decoders.
REQ-009 heating  output  1  high only while counting down.
REQ-010 done  output  1  high while the alarm is held.
REQ-011 state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-012 press SHALL be pushButton & ~pb_q, where pb_q is pushButton registered; press lasts 1 clk per rising edge.
REQ-013 IDLE, press with in<=9: shift the digits left by one position (min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=in); the old min_tens is discarded.
REQ-014 Seconds field SHALL accept entries 00-99 (microwave style); no entry is rejected or normalized.
REQ-015 IDLE, press with in=A and time nonzero: go to RUN. If time is 0000, the press is ignored and the block stays in IDLE.
REQ-016 IDLE, press with in=C: zero all four digits.
REQ-017 RUN, tick with onOff=0: decrement by one second.
  - sec_ones>0: sec_ones-1.
  - sec_ones=0, sec_tens>0: sec_ones=9, sec_tens-1.
  - seconds=00, min_ones>0: seconds=59, min_ones-1.
  - seconds=00, min_ones=0, min_tens>0: min_ones=9, min_tens-1, seconds=59.
REQ-018 RUN: the tick that takes the time to 0000 SHALL, in the same edge, move to DONE and clear the alarm tick counter.
REQ-019 RUN with onOff=1: go to PAUSE on the next edge; a tick in that same cycle is ignored.
REQ-020 PAUSE: digits frozen and ticks ignored; press in=A with onOff=0 returns to RUN; press in=C returns to IDLE with digits zeroed.
REQ-021 RUN, press in=C: go to IDLE with digits zeroed; C takes priority over a simultaneous tick.
REQ-022 RUN, press of any other code: ignored.
REQ-023 DONE: digits stay 0000; each tick increments the alarm counter; the tick that brings the count to DONE_SECS returns the block to IDLE.
REQ-024 DONE, any press: return to IDLE immediately; press takes priority over a simultaneous tick.
REQ-025 Outputs heating = (state==RUN) and done = (state==DONE), both registered and decoded from the state register.
REQ-026 Digit arithmetic SHALL stay BCD; no digit ever exceeds 9.

Reset
REQ-027 With reset=1 at a clk edge: state=IDLE, all digits=0, heating=0, done=0, alarm counter=0.
REQ-028 During reset, pb_q SHALL load pushButton, so a button held through reset produces no press.
REQ-029 Reset SHALL override every other input in every state, including mid-countdown.

Verification
REQ-030 Entry: press in=1, 3, 0 -> digits 0,1,3,0; press in=A -> state=RUN, heating=1.
REQ-031 Borrow: start at 01:00, one tick -> 00:59; start at 10:00, one tick -> 09:59; start at 00:90, one tick -> 00:89.
REQ-032 Completion: start at 00:02, two ticks -> 00:00 with state=DONE and done=1; DONE_SECS further ticks -> IDLE, done=0.
REQ-033 Pause: in RUN at 00:30, onOff=1 plus 3 ticks -> 00:30, PAUSE, heating=0; onOff=0 plus press A -> RUN.
REQ-034 Priority: in RUN, press C in the same cycle as a tick -> IDLE with 0000; press A at 0000 in IDLE -> stays IDLE.
REQ-035 Reset mid-RUN at 05:17 -> next cycle IDLE with 0000; pushButton held high through reset -> no digit shifted.
